// File: rtl/gpu_pkg.sv
// Shared types and constants for the kernel block dispatcher.
// Contents: top FSM state enum, per-core slot state enum, counter and ID
// widths, and a helper that sizes the per-block thread-count field.
package gpu_pkg;

  localparam int unsigned BLOCK_ID_BITS     = 8;
  localparam int unsigned THREAD_COUNT_BITS = 8;
  // Block counters hold ceil(255/1) = 255 at most, 9 bits leaves headroom.
  localparam int unsigned CNT_BITS          = 9;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } dispatch_state_t;

  typedef enum logic {
    FREE,
    BUSY
  } slot_state_t;

  // Width of a per-block thread count: must represent 0..tpb inclusive.
  function automatic int unsigned tc_bits(int unsigned tpb);
    return $clog2(tpb) + 1;
  endfunction

endpackage

// File: rtl/dispatcher_if.sv
// Dispatcher <-> core-array bus.
// master (dispatcher): drives core_start, core_reset, core_block_id,
//                      core_thread_count; samples core_done.
// slave  (core array): the reverse.
interface dispatcher_if
  import gpu_pkg::*;
#(
  parameter int unsigned NUM_CORES         = 2,
  parameter int unsigned THREADS_PER_BLOCK = 4
) ();

  localparam int unsigned TC_BITS = tc_bits(THREADS_PER_BLOCK);

  logic [NUM_CORES-1:0]                    core_start;
  logic [NUM_CORES-1:0]                    core_reset;
  logic [NUM_CORES-1:0][BLOCK_ID_BITS-1:0] core_block_id;
  logic [NUM_CORES-1:0][TC_BITS-1:0]       core_thread_count;
  logic [NUM_CORES-1:0]                    core_done;

  modport master (
    output core_start,
    output core_reset,
    output core_block_id,
    output core_thread_count,
    input  core_done
  );

  modport slave (
    input  core_start,
    input  core_reset,
    input  core_block_id,
    input  core_thread_count,
    output core_done
  );

endinterface

// File: rtl/dispatch_slot.sv
// Per-core dispatch slot: tracks whether its core is FREE or running a block
// and holds the registered core controls for that core.
// Ports:
//   clk, reset          clock, synchronous active-low reset
//   assign_i            load block_id_i/thread_count_i and start the core
//   block_id_i          block ID to hand to the core
//   thread_count_i      active threads in that block
//   core_done_i         core has finished its block (level)
//   free_o              slot may accept a block this cycle
//   complete_c          slot is finishing a block at the coming edge
//   core_reset_o        active-high core reset, high while FREE
//   core_start_o        core run enable, high while BUSY
//   core_block_id_o     registered block ID
//   core_thread_count_o registered thread count
module dispatch_slot
  import gpu_pkg::*;
#(
  parameter int unsigned TC_BITS = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     assign_i,
  input  logic [BLOCK_ID_BITS-1:0] block_id_i,
  input  logic [TC_BITS-1:0]       thread_count_i,
  input  logic                     core_done_i,
  output logic                     free_o,
  output logic                     complete_c,
  output logic                     core_reset_o,
  output logic                     core_start_o,
  output logic [BLOCK_ID_BITS-1:0] core_block_id_o,
  output logic [TC_BITS-1:0]       core_thread_count_o
);

  slot_state_t              state_q;
  logic                     core_reset_q;
  logic                     core_start_q;
  logic [BLOCK_ID_BITS-1:0] block_id_q;
  logic [TC_BITS-1:0]       thread_count_q;

  // A freed slot only becomes pickable after the edge that frees it.
  assign free_o     = (state_q == FREE);
  assign complete_c = (state_q == BUSY) && core_done_i;

  // Slot state plus registered core controls; ID/count hold after completion.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= FREE;
      core_reset_q   <= 1'b1;
      core_start_q   <= 1'b0;
      block_id_q     <= '0;
      thread_count_q <= '0;
    end else begin
      case (state_q)
        FREE: begin
          if (assign_i) begin
            state_q        <= BUSY;
            core_reset_q   <= 1'b0;
            core_start_q   <= 1'b1;
            block_id_q     <= block_id_i;
            thread_count_q <= thread_count_i;
          end
        end
        BUSY: begin
          if (core_done_i) begin
            state_q      <= FREE;
            core_reset_q <= 1'b1;
            core_start_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= FREE;
          core_reset_q <= 1'b1;
          core_start_q <= 1'b0;
        end
      endcase
    end
  end

  assign core_reset_o        = core_reset_q;
  assign core_start_o        = core_start_q;
  assign core_block_id_o     = block_id_q;
  assign core_thread_count_o = thread_count_q;

endmodule

// File: rtl/dispatcher.sv
// Kernel block dispatcher: splits a launch of thread_count threads into
// blocks of THREADS_PER_BLOCK, hands them to free cores lowest-index first
// (one per cycle), counts completions and raises done when all have finished.
// Ports:
//   clk, reset    clock, synchronous active-low reset
//   start         launch request (level), sampled only in IDLE
//   thread_count  total kernel threads, captured on launch
//   done          kernel complete, held until start drops
//   core_bus      per-core start/reset/block ID/thread count out, done in
module dispatcher
  import gpu_pkg::*;
#(
  parameter int unsigned NUM_CORES         = 2,
  parameter int unsigned THREADS_PER_BLOCK = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [THREAD_COUNT_BITS-1:0] thread_count,
  output logic                         done,
  dispatcher_if.master                 core_bus
);

  localparam int unsigned LOG2_TPB   = $clog2(THREADS_PER_BLOCK);
  localparam int unsigned TC_BITS    = tc_bits(THREADS_PER_BLOCK);
  localparam int unsigned ARITH_BITS = 16;

  dispatch_state_t              state_q;
  logic [THREAD_COUNT_BITS-1:0] tc_q;
  logic [CNT_BITS-1:0]          total_q;
  logic [CNT_BITS-1:0]          dispatched_q;
  logic [CNT_BITS-1:0]          completed_q;
  logic                         done_q;

  logic [CNT_BITS-1:0]          total_c;
  logic [CNT_BITS-1:0]          done_cnt_c;
  logic [CNT_BITS-1:0]          completed_d;
  logic [ARITH_BITS-1:0]        remaining_c;
  logic [TC_BITS-1:0]           blk_tc_c;
  logic                         dispatch_c;
  logic [NUM_CORES-1:0]         free_v;
  logic [NUM_CORES-1:0]         complete_v;
  logic [NUM_CORES-1:0]         assign_c;

  logic                         free_w         [NUM_CORES];
  logic                         complete_w     [NUM_CORES];
  logic                         core_reset_w   [NUM_CORES];
  logic                         core_start_w   [NUM_CORES];
  logic [BLOCK_ID_BITS-1:0]     core_bid_w     [NUM_CORES];
  logic [TC_BITS-1:0]           core_tc_w      [NUM_CORES];

  // ceil(thread_count / TPB) in 9-bit arithmetic
  assign total_c = CNT_BITS'(({1'b0, thread_count} + CNT_BITS'(THREADS_PER_BLOCK - 1))
                             >> LOG2_TPB);

  // Threads left for the block about to be dispatched, clipped to TPB.
  assign remaining_c = ARITH_BITS'(tc_q) - (ARITH_BITS'(dispatched_q) << LOG2_TPB);
  assign blk_tc_c    = (remaining_c >= ARITH_BITS'(THREADS_PER_BLOCK))
                       ? TC_BITS'(THREADS_PER_BLOCK) : TC_BITS'(remaining_c);

  // Lowest-index free slot wins: isolate the least significant set bit.
  assign dispatch_c = (state_q == RUN) && (dispatched_q < total_q) && (|free_v);
  assign assign_c   = dispatch_c ? (free_v & (~free_v + NUM_CORES'(1))) : '0;

  // Popcount of slots completing this cycle.
  always_comb begin
    done_cnt_c = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      done_cnt_c = done_cnt_c + CNT_BITS'(complete_v[i]);
    end
  end

  assign completed_d = completed_q + done_cnt_c;

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_slot
    dispatch_slot #(
      .TC_BITS (TC_BITS)
    ) u_slot (
      .clk                 (clk),
      .reset               (reset),
      .assign_i            (assign_c[g]),
      .block_id_i          (BLOCK_ID_BITS'(dispatched_q)),
      .thread_count_i      (blk_tc_c),
      .core_done_i         (core_bus.core_done[g]),
      .free_o              (free_w[g]),
      .complete_c          (complete_w[g]),
      .core_reset_o        (core_reset_w[g]),
      .core_start_o        (core_start_w[g]),
      .core_block_id_o     (core_bid_w[g]),
      .core_thread_count_o (core_tc_w[g])
    );
  end

  // Gather per-slot signals onto packed vectors and the core bus.
  always_comb begin
    free_v                     = '0;
    complete_v                 = '0;
    core_bus.core_start        = '0;
    core_bus.core_reset        = '0;
    core_bus.core_block_id     = '0;
    core_bus.core_thread_count = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      free_v[i]                     = free_w[i];
      complete_v[i]                 = complete_w[i];
      core_bus.core_start[i]        = core_start_w[i];
      core_bus.core_reset[i]        = core_reset_w[i];
      core_bus.core_block_id[i]     = core_bid_w[i];
      core_bus.core_thread_count[i] = core_tc_w[i];
    end
  end

  // Kernel FSM and block counters. DONE is entered on the edge that counts
  // the final completion; done follows the state one edge later.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      tc_q         <= '0;
      total_q      <= '0;
      dispatched_q <= '0;
      completed_q  <= '0;
      done_q       <= 1'b0;
    end else begin
      done_q <= (state_q == DONE);
      case (state_q)
        IDLE: begin
          if (start) begin
            tc_q         <= thread_count;
            total_q      <= total_c;
            dispatched_q <= '0;
            completed_q  <= '0;
            state_q      <= RUN;
          end
        end
        RUN: begin
          if (dispatch_c) begin
            dispatched_q <= dispatched_q + CNT_BITS'(1);
          end
          completed_q <= completed_d;
          if (completed_d == total_q) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (!start) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done = done_q;

endmodule

// File: tb/tb_dispatcher.sv
// Bench for dispatcher: table-driven directed scenarios plus randomized
// kernels with randomly delayed core completions, all checked against a
// block-level reference model of the dispatch rules.
module tb_dispatcher;

  localparam int NC  = 2;
  localparam int TPB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] thread_count;
  logic       done;

  dispatcher_if #(.NUM_CORES(NC), .THREADS_PER_BLOCK(TPB)) bus ();

  dispatcher #(.NUM_CORES(NC), .THREADS_PER_BLOCK(TPB)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .thread_count (thread_count),
    .done         (done),
    .core_bus     (bus.master)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cycle       = 0;

  // Reference model: phase 0 idle, 1 running, 2 finished.
  int          m_phase     = 0;
  int          m_tc        = 0;
  int          m_total     = 0;
  int          m_next      = 0;
  int          m_completed = 0;
  bit [NC-1:0] m_busy      = '0;
  int          m_bid  [NC];
  int          m_tcnt [NC];
  bit          m_done      = 1'b0;

  logic [2*NC:0]    obs_ctl, exp_ctl;
  logic [NC*11-1:0] obs_pay, exp_pay;

  // Auto core model: each started core finishes after a random delay.
  bit          auto_cores = 1'b0;
  int          max_delay  = 0;
  int          cnt   [NC];
  bit          armed [NC];
  logic [NC-1:0] cd;

  // Apply one clock edge of dispatch rules to the model using current inputs.
  task automatic model_edge();
    bit nd;
    int pick;
    int ncomp;
    if (!reset) begin
      m_phase = 0; m_busy = '0; m_done = 1'b0;
      m_next = 0; m_completed = 0; m_total = 0;
      return;
    end
    nd = (m_phase == 2);
    case (m_phase)
      0: if (start) begin
        m_tc = int'(thread_count);
        m_total = (m_tc + TPB - 1) / TPB;
        m_next = 0; m_completed = 0; m_phase = 1;
      end
      1: begin
        pick = -1;
        if (m_next < m_total)
          for (int c = NC - 1; c >= 0; c--) if (!m_busy[c]) pick = c;
        ncomp = 0;
        for (int c = 0; c < NC; c++)
          if (m_busy[c] && bus.core_done[c]) begin m_busy[c] = 1'b0; ncomp++; end
        if (pick >= 0) begin
          m_busy[pick] = 1'b1;
          m_bid[pick]  = m_next;
          m_tcnt[pick] = (m_tc - m_next * TPB < TPB) ? m_tc - m_next * TPB : TPB;
          m_next++;
        end
        m_completed += ncomp;
        if (m_completed == m_total) m_phase = 2;
      end
      default: if (!start) m_phase = 0;
    endcase
    m_done = nd;
  endtask

  // Advance one edge, sample 1 time unit later, then react as the cores.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    cycle++;
    obs_ctl = {bus.core_start, bus.core_reset, done};
    exp_ctl = {m_busy, ~m_busy, m_done};
    obs_pay = '0;
    exp_pay = '0;
    for (int c = 0; c < NC; c++) begin
      if (m_busy[c]) begin
        obs_pay[c*11 +: 11] = {bus.core_block_id[c], bus.core_thread_count[c]};
        exp_pay[c*11 +: 11] = {8'(m_bid[c]), 3'(m_tcnt[c])};
      end
    end
    if (auto_cores) begin
      for (int c = 0; c < NC; c++) begin
        if (bus.core_reset[c]) begin
          cd[c] = 1'b0; armed[c] = 1'b0;
        end else if (!armed[c]) begin
          armed[c] = 1'b1;
          cnt[c] = int'($urandom_range(max_delay, 0));
          cd[c] = (cnt[c] == 0);
        end else if (cnt[c] > 0) begin
          cnt[c]--;
          cd[c] = (cnt[c] == 0);
        end
      end
      bus.core_done = cd;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; thread_count = '0; bus.core_done = '0;
    tick();
    tick();
    vectors++; if (bus.core_start !== 2'b00) begin miscompares++; $display("FAIL reset_start got=%b want=00", bus.core_start); end
    vectors++; if (bus.core_reset !== 2'b11) begin miscompares++; $display("FAIL reset_reset got=%b want=11", bus.core_reset); end
    vectors++; if (bus.core_block_id !== 16'h0) begin miscompares++; $display("FAIL reset_bid got=%h want=0", bus.core_block_id); end
    vectors++; if (bus.core_thread_count !== 6'h0) begin miscompares++; $display("FAIL reset_tcnt got=%h want=0", bus.core_thread_count); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b want=0", done); end
    reset = 1'b1;
    tick();
    vectors++; if (obs_ctl !== exp_ctl) begin miscompares++; $display("FAIL reset_idle_ctl got=%b want=%b", obs_ctl, exp_ctl); end
  endtask

  // thread_count=8: two full blocks, completions on different edges.
  task automatic test_full_blocks();
    bit [1:0] st_t [9] = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
    bit [1:0] cd_t [9] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
    bit [1:0] cs_t [9] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    bit       dn_t [9] = '{0, 0, 0, 0, 0, 1, 1, 1, 0};
    thread_count = 8'd8;
    for (int s = 0; s < 9; s++) begin
      start = st_t[s][0]; bus.core_done = cd_t[s];
      tick();
      vectors++; if (bus.core_start !== cs_t[s]) begin miscompares++; $display("FAIL full_start step=%0d got=%b want=%b", s, bus.core_start, cs_t[s]); end
      vectors++; if (done !== dn_t[s]) begin miscompares++; $display("FAIL full_done step=%0d got=%b want=%b", s, done, dn_t[s]); end
      vectors++; if (obs_ctl !== exp_ctl) begin miscompares++; $display("FAIL full_ctl step=%0d got=%b want=%b", s, obs_ctl, exp_ctl); end
      vectors++; if (obs_pay !== exp_pay) begin miscompares++; $display("FAIL full_pay step=%0d got=%h want=%h", s, obs_pay, exp_pay); end
      if (s == 2) begin
        vectors++; if ({bus.core_block_id[1], bus.core_thread_count[1]} !== {8'd1, 3'd4}) begin
          miscompares++; $display("FAIL full_core1 got=%0d/%0d want=1/4", bus.core_block_id[1], bus.core_thread_count[1]); end
      end
    end
  endtask

  // thread_count=12: both cores finish on the same edge, third block follows.
  task automatic test_simultaneous();
    bit [1:0] st_t [9] = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
    bit [1:0] cd_t [9] = '{2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
    bit [1:0] cs_t [9] = '{2'b00, 2'b01, 2'b11, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    bit       dn_t [9] = '{0, 0, 0, 0, 0, 0, 1, 1, 0};
    thread_count = 8'd12;
    for (int s = 0; s < 9; s++) begin
      start = st_t[s][0]; bus.core_done = cd_t[s];
      tick();
      vectors++; if (bus.core_start !== cs_t[s]) begin miscompares++; $display("FAIL simul_start step=%0d got=%b want=%b", s, bus.core_start, cs_t[s]); end
      vectors++; if (done !== dn_t[s]) begin miscompares++; $display("FAIL simul_done step=%0d got=%b want=%b", s, done, dn_t[s]); end
      vectors++; if (obs_ctl !== exp_ctl) begin miscompares++; $display("FAIL simul_ctl step=%0d got=%b want=%b", s, obs_ctl, exp_ctl); end
      vectors++; if (obs_pay !== exp_pay) begin miscompares++; $display("FAIL simul_pay step=%0d got=%h want=%h", s, obs_pay, exp_pay); end
      if (s == 4) begin
        vectors++; if ({bus.core_block_id[0], bus.core_thread_count[0]} !== {8'd2, 3'd4}) begin
          miscompares++; $display("FAIL simul_block2 got=%0d/%0d want=2/4", bus.core_block_id[0], bus.core_thread_count[0]); end
      end
    end
  endtask

  // thread_count=0: no core ever starts, done after E2, held while start high.
  task automatic test_zero();
    bit st_t [7] = '{1, 1, 1, 1, 1, 0, 0};
    bit dn_t [7] = '{0, 0, 1, 1, 1, 1, 0};
    thread_count = 8'd0; bus.core_done = '0;
    for (int s = 0; s < 7; s++) begin
      start = st_t[s];
      tick();
      vectors++; if (bus.core_start !== 2'b00) begin miscompares++; $display("FAIL zero_start step=%0d got=%b want=00", s, bus.core_start); end
      vectors++; if (done !== dn_t[s]) begin miscompares++; $display("FAIL zero_done step=%0d got=%b want=%b", s, done, dn_t[s]); end
      vectors++; if (obs_ctl !== exp_ctl) begin miscompares++; $display("FAIL zero_ctl step=%0d got=%b want=%b", s, obs_ctl, exp_ctl); end
    end
  endtask

  // Random kernels (first one 20 threads) with random completion delays.
  task automatic test_random_kernels();
    int tcs [4];
    int ids [$];
    bit [NC-1:0] prev;
    int frees;
    int total;
    bit fin;
    tcs = '{20, 6, int'($urandom_range(60, 1)), int'($urandom_range(255, 61))};
    auto_cores = 1'b1;
    for (int k = 0; k < 4; k++) begin
      max_delay = (k == 3) ? 2 : 5;
      for (int c = 0; c < NC; c++) begin armed[c] = 1'b0; cd[c] = 1'b0; end
      bus.core_done = '0;
      ids.delete(); prev = '0; frees = 0; fin = 1'b0;
      total = (tcs[k] + TPB - 1) / TPB;
      thread_count = 8'(tcs[k]); start = 1'b1;
      for (int n = 0; n < 2000 && !fin; n++) begin
        tick();
        if (n == 2) start = 1'b0;
        vectors++; if (obs_ctl !== exp_ctl) begin miscompares++; $display("FAIL rand_ctl tc=%0d cyc=%0d got=%b want=%b", tcs[k], cycle, obs_ctl, exp_ctl); end
        vectors++; if (obs_pay !== exp_pay) begin miscompares++; $display("FAIL rand_pay tc=%0d cyc=%0d got=%h want=%h", tcs[k], cycle, obs_pay, exp_pay); end
        for (int c = 0; c < NC; c++) begin
          if (bus.core_start[c] && !prev[c]) begin
            ids.push_back(int'(bus.core_block_id[c]));
            if (tcs[k] == 6 && bus.core_block_id[c] == 8'd1) begin
              vectors++; if (bus.core_thread_count[c] !== 3'd2) begin miscompares++; $display("FAIL partial_tcnt got=%0d want=2", bus.core_thread_count[c]); end
            end
          end
          if (!bus.core_start[c] && prev[c]) frees++;
        end
        prev = bus.core_start;
        if (done === 1'b1) begin
          fin = 1'b1;
          vectors++; if (frees != total) begin miscompares++; $display("FAIL rand_early_done tc=%0d completions=%0d want=%0d", tcs[k], frees, total); end
        end
      end
      vectors++; if (!fin) begin miscompares++; $display("FAIL rand_timeout tc=%0d done=%b want=1", tcs[k], done); end
      vectors++; if (ids.size() != total) begin miscompares++; $display("FAIL rand_count tc=%0d got=%0d want=%0d", tcs[k], ids.size(), total); end
      for (int i = 0; i < ids.size(); i++) begin
        vectors++; if (ids[i] != i) begin miscompares++; $display("FAIL rand_order tc=%0d idx=%0d got=%0d want=%0d", tcs[k], i, ids[i], i); end
      end
      start = 1'b0;
      tick();
      tick();
      vectors++; if (obs_ctl !== exp_ctl) begin miscompares++; $display("FAIL rand_idle_ctl got=%b want=%b", obs_ctl, exp_ctl); end
    end
    auto_cores = 1'b0;
    bus.core_done = '0;
  endtask

  // Reset while core 1 is busy, then a one-block relaunch.
  task automatic test_reset_midrun();
    bit core1_seen = 1'b0;
    thread_count = 8'd20; start = 1'b1; bus.core_done = '0;
    tick(); tick(); tick();
    vectors++; if (bus.core_start !== 2'b11) begin miscompares++; $display("FAIL midrun_busy got=%b want=11", bus.core_start); end
    reset = 1'b0; start = 1'b0;
    tick();
    vectors++; if ({bus.core_start, bus.core_reset, done} !== 5'b00110) begin
      miscompares++; $display("FAIL midrun_ctl got=%b want=00110", {bus.core_start, bus.core_reset, done}); end
    vectors++; if ({bus.core_block_id, bus.core_thread_count} !== 22'h0) begin
      miscompares++; $display("FAIL midrun_pay got=%h want=0", {bus.core_block_id, bus.core_thread_count}); end
    reset = 1'b1;
    tick();
    thread_count = 8'd4; start = 1'b1;
    for (int s = 0; s < 8; s++) begin
      bus.core_done = (s == 3) ? 2'b01 : 2'b00;
      if (s == 5) start = 1'b0;
      tick();
      if (bus.core_start[1]) core1_seen = 1'b1;
      vectors++; if (obs_ctl !== exp_ctl) begin miscompares++; $display("FAIL relaunch_ctl step=%0d got=%b want=%b", s, obs_ctl, exp_ctl); end
      vectors++; if (obs_pay !== exp_pay) begin miscompares++; $display("FAIL relaunch_pay step=%0d got=%h want=%h", s, obs_pay, exp_pay); end
      if (s == 1) begin
        vectors++; if ({bus.core_start[0], bus.core_block_id[0], bus.core_thread_count[0]} !== {1'b1, 8'd0, 3'd4}) begin
          miscompares++; $display("FAIL relaunch_core0 got=%b/%0d/%0d want=1/0/4", bus.core_start[0], bus.core_block_id[0], bus.core_thread_count[0]); end
      end
      if (s == 4) begin
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL relaunch_done got=%b want=1", done); end
      end
    end
    vectors++; if (core1_seen) begin miscompares++; $display("FAIL relaunch_core1 got=started want=idle"); end
  endtask

  initial begin
    test_reset();
    test_full_blocks();
    test_simultaneous();
    test_zero();
    test_random_kernels();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cycle=%0d", cycle);
    $fatal(1, "bench did not finish");
  end

endmodule

// File: doc/dispatcher.md
# dispatcher

Kernel-level block dispatcher for the GPU: splits a launch of `thread_count` threads into blocks of `THREADS_PER_BLOCK` and sequences them onto `NUM_CORES` compute cores. For each core it drives reset, start, block ID and per-block thread count, then collects each core's `done`. It sits between the top-level device control (start/done, thread-count register) and the core array. It signals kernel completion once every block has finished.

## Interface
- `NUM_CORES`, 2, number of compute cores driven (≥1)
- `THREADS_PER_BLOCK`, 4, max threads per block; power of two, ≥1
- `clk`  in  1  clock; all logic on rising edge
- `reset`  in  1  synchronous, active-low reset
- `start`  in  1  kernel launch request, level; sampled only in IDLE
- `thread_count`  in  8  total threads in the kernel; captured on launch
- `core_start`  out  [NUM_CORES]  per-core start, held high while the core runs a block
- `core_reset`  out  [NUM_CORES]  per-core reset, active-high; high while the core is unassigned
- `core_block_id`  out  8 × NUM_CORES  block ID for each core
- `core_thread_count`  out  ($clog2(THREADS_PER_BLOCK)+1) × NUM_CORES  active threads in the assigned block
- `core_done`  in  [NUM_CORES]  core finished its block; level, cleared by core reset
- `done`  out  1  kernel complete

## Operation
- Top FSM states:
  - IDLE: on `start`=1, latch `thread_count`, compute `total_blocks` = ceil(thread_count / THREADS_PER_BLOCK) in 9-bit arithmetic, clear `dispatched` and `completed` counters, go to RUN.
  - RUN: dispatch blocks and count completions. When `completed` == `total_blocks`, go to DONE.
  - DONE: `done`=1; go to IDLE when `start`=0.
- Per-core slot states:
  - FREE: `core_reset`=1, `core_start`=0.
  - BUSY: `core_reset`=0, `core_start`=1.
- Dispatch: in RUN, when `dispatched` < `total_blocks`, pick the lowest-index FREE core. At most one dispatch per cycle.
  - On dispatch: load `core_block_id` ← `dispatched`; load `core_thread_count` ← min(THREADS_PER_BLOCK, thread_count − dispatched·THREADS_PER_BLOCK); increment `dispatched`; slot goes to BUSY.
- Completion: a BUSY slot seeing `core_done`=1 returns to FREE. `completed` increases by the number of slots completing that cycle, so simultaneous completions all count.
- A core freed in cycle N can be redispatched in cycle N+1.
- `thread_count`=0: `total_blocks`=0, so RUN goes to DONE on the first RUN cycle with no core started.
- `start` dropping during RUN is ignored; the kernel runs to completion.
- `core_block_id` and `core_thread_count` hold their values after completion; they are don't-care while the slot is FREE.
- Reset (`reset`=0 at an edge, including mid-kernel): FSM to IDLE, all slots FREE, counters 0.
  - Output reset values: `done`=0, `core_start`=0, `core_reset`=all ones, `core_block_id`=0, `core_thread_count`=0.

## Timing
- All outputs are registered.
- Edge E0 samples `start`=1 in IDLE; FSM is in RUN after E0.
- The first dispatch decision is made in the cycle after E0. Core 0 sees `core_reset`=0, `core_start`=1 and valid block ID and thread count from E1.
- Subsequent cores are enabled on consecutive edges E2, E3, …
- Completion latency: `core_done` sampled at edge Ek puts the slot in FREE (`core_reset`=1, `core_start`=0) after Ek.
- After the last completion edge Ek, FSM enters DONE and `done`=1 after Ek+1.
- `done` falls one edge after `start` is sampled low in DONE.
- A new launch is accepted the edge after returning to IDLE.

## Structure
- Shared package `gpu_pkg` holds:
  - `dispatch_state_t` enum {IDLE, RUN, DONE}
  - `slot_state_t` enum {FREE, BUSY}
  - constant `BLOCK_ID_BITS`=8
- Sub-module `dispatch_slot`, one instance per core. It owns the slot state, `core_reset`, `core_start`, block ID and thread-count registers. Its inputs are `assign`, block ID, thread count and `core_done`. Its outputs are `free` and `complete`.
- The top level holds the FSM, counters, priority picker and completion popcount.

## Test plan
- NUM_CORES=2, TPB=4, thread_count=8.
  - Core 0 gets block 0 / 4 threads after E1.
  - Core 1 gets block 1 / 4 threads after E2.
  - Both assert done → `done`=1 two edges after the later done.
- thread_count=6: second block has `core_thread_count`=2.
- thread_count=20 (5 blocks, 2 cores), random done delays:
  - block IDs 0–4 each dispatched exactly once, in increasing order;
  - a freed core is redispatched on the next edge;
  - `done` only after 5 completions.
- Both cores assert `core_done` on the same edge: `completed` increments by 2 and no completion is lost.
- thread_count=0: `done`=1 after E2 with no `core_start` ever high. `start` held high keeps `done` high; dropping it returns to IDLE.
- `reset`=0 mid-run with core 1 BUSY: after the edge, all outputs are at reset values. A fresh launch with thread_count=4 then runs block 0 on core 0 only.
